// File: rtl/stopwatch_ctrl_pkg.sv
// Shared state encodings, button indices and default timing constants
// for the stopwatch controller and the display top.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } sw_state_e;

  localparam int TICK_DIV_DEF   = 1000;
  localparam int DEB_CYCLES_DEF = 20;

  localparam int NUM_BTN   = 2;
  localparam int BTN_START = 0;
  localparam int BTN_CLEAR = 1;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-control outputs of the stopwatch controller.
interface stopwatch_ctrl_if;
  import stopwatch_ctrl_pkg::*;

  logic      btn_start;
  logic      btn_clear;
  logic      tick;
  logic      cnt_clr;
  logic      running;
  sw_state_e state;

  modport master (output btn_start, output btn_clear,
                  input tick, input cnt_clr, input running, input state);
  modport slave  (input btn_start, input btn_clear,
                  output tick, output cnt_clr, output running, output state);
endinterface

// File: rtl/stopwatch_ctrl_debounce.sv
// One pushbutton: 2-flop synchronizer, debounce counter, registered
// rising-edge press pulse.
module btn_debounce #(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);
  localparam int              CW      = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_TOP = CW'(DEB_CYCLES);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;
  logic          lvl_dly_q;
  logic          press_q;

  // The level flips on the sample after the counter has seen the
  // disagreement persist long enough; this fixes press latency at
  // DEB_CYCLES+3 edges after the raw sample.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q == CNT_TOP) lvl_d = sync_q[1];
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      lvl_q     <= 1'b0;
      lvl_dly_q <= 1'b0;
      press_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], btn_raw};
      cnt_q     <= cnt_d;
      lvl_q     <= lvl_d;
      lvl_dly_q <= lvl_q;
      press_q   <= lvl_q & ~lvl_dly_q;
    end
  end

  assign level = lvl_q;
  assign press = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch start/stop/clear FSM with gated count-tick prescaler;
// drives the digit counters' tick and synchronous clear.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [NUM_BTN-1:0] raw, lvl, prs;
  logic               unused_lvl;

  assign raw[BTN_START] = sw.btn_start;
  assign raw[BTN_CLEAR] = sw.btn_clear;
  assign unused_lvl     = ^lvl;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(raw[g]),
      .level  (lvl[g]),
      .press  (prs[g])
    );
  end

  sw_state_e     state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          run_q;

  // In RUN a clear is ignored so start wins; elsewhere clear outranks start.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (prs[BTN_CLEAR])      clr_d   = 1'b1;
        else if (prs[BTN_START]) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (prs[BTN_START]) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (prs[BTN_CLEAR]) begin
          state_d = ST_IDLE;
          clr_d   = 1'b1;
        end else if (prs[BTN_START]) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        clr_d   = 1'b1;
      end
    endcase
  end

  // Prescaler advances on current state so a wrap coinciding with a pause
  // still ticks; it freezes in PAUSE and zeroes on any move into IDLE.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_q == ST_RUN) begin
      if (presc_q == PRESC_MAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
    if (state_d == ST_IDLE) presc_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign sw.state   = state_q;
  assign sw.tick    = tick_q;
  assign sw.cnt_clr = clr_q;
  assign sw.running = run_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DEB_CYCLES=4, TICK_DIV=10.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  stopwatch_ctrl_if sif ();

  stopwatch_ctrl #(.TICK_DIV(10), .DEB_CYCLES(4)) u_dut (
    .clk(clk),
    .rst(rst),
    .sw (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Raw buttons go high just after edge e (first sampled at e+1) for 6 edges;
  // returns just after edge e+8, one edge before the state must move.
  task automatic press(input logic s, input logic c);
    sif.btn_start = s;
    sif.btn_clear = c;
    cyc(6);
    sif.btn_start = 1'b0;
    sif.btn_clear = 1'b0;
    cyc(2);
  endtask

  task automatic test_reset;
    int ticks, bad;
    cyc(3);
    n_run++; if (sif.state !== ST_IDLE) begin n_fail++; $display("FAIL rst_state: got %0d want %0d", sif.state, ST_IDLE); end
    n_run++; if (sif.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL rst_cnt_clr: got %b want 1", sif.cnt_clr); end
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick: got %b want 0", sif.tick); end
    n_run++; if (sif.running !== 1'b0) begin n_fail++; $display("FAIL rst_running: got %b want 0", sif.running); end
    rst = 1'b1;
    cyc(1);
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL rst_clr_pulse: got %b want 0", sif.cnt_clr); end
    ticks = 0; bad = 0;
    repeat (100) begin
      cyc(1);
      if (sif.tick !== 1'b0) ticks++;
      if (sif.state !== ST_IDLE) bad++;
    end
    n_run++; if (ticks != 0) begin n_fail++; $display("FAIL idle_no_tick: got %0d ticks want 0", ticks); end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL idle_hold: got %0d non-idle cycles want 0", bad); end
  endtask

  task automatic test_glitch;
    int bad;
    bad = 0;
    sif.btn_start = 1'b1;
    cyc(3);
    sif.btn_start = 1'b0;
    repeat (14) begin
      cyc(1);
      if (sif.state !== ST_IDLE) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL glitch: got %0d non-idle cycles want 0", bad); end
  endtask

  task automatic test_start_run;
    press(1'b1, 1'b0);
    n_run++; if (sif.state !== ST_IDLE) begin n_fail++; $display("FAIL start_early: got %0d want %0d", sif.state, ST_IDLE); end
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL start_state: got %0d want %0d", sif.state, ST_RUN); end
    n_run++; if (sif.running !== 1'b1) begin n_fail++; $display("FAIL start_running: got %b want 1", sif.running); end
    cyc(9);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL tick1_early: got %b want 0", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL tick1: got %b want 1", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL tick1_width: got %b want 0", sif.tick); end
    cyc(8);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL tick2_early: got %b want 0", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL tick2: got %b want 1", sif.tick); end
  endtask

  // Pause lands when the prescaler holds 5; resume must tick after 5 RUN cycles.
  task automatic test_pause_resume;
    cyc(6);
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL pause_state: got %0d want %0d", sif.state, ST_PAUSE); end
    n_run++; if (sif.running !== 1'b0) begin n_fail++; $display("FAIL pause_running: got %b want 0", sif.running); end
    cyc(3);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL pause_tick: got %b want 0", sif.tick); end
    press(1'b1, 1'b0);
    n_run++; if (sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL resume_early: got %0d want %0d", sif.state, ST_PAUSE); end
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL resume_state: got %0d want %0d", sif.state, ST_RUN); end
    cyc(4);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL resume_tick_early: got %b want 0", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL resume_tick: got %b want 1", sif.tick); end
  endtask

  task automatic test_clear;
    cyc(2);
    press(1'b0, 1'b1);
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL clr_in_run_state: got %0d want %0d", sif.state, ST_RUN); end
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_in_run_pulse: got %b want 0", sif.cnt_clr); end
    cyc(2);
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL clr_pause: got %0d want %0d", sif.state, ST_PAUSE); end
    cyc(2);
    press(1'b0, 1'b1);
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_early: got %b want 0", sif.cnt_clr); end
    cyc(1);
    n_run++; if (sif.state !== ST_IDLE) begin n_fail++; $display("FAIL clr_state: got %0d want %0d", sif.state, ST_IDLE); end
    n_run++; if (sif.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL clr_pulse: got %b want 1", sif.cnt_clr); end
    cyc(1);
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL clr_pulse_width: got %b want 0", sif.cnt_clr); end
    // A cleared prescaler gives a full TICK_DIV before the first tick.
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL restart_state: got %0d want %0d", sif.state, ST_RUN); end
    cyc(9);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL restart_tick_early: got %b want 0", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL restart_tick: got %b want 1", sif.tick); end
  endtask

  task automatic test_simultaneous;
    // Both pressed in RUN, landing on the prescaler wrap edge.
    cyc(1);
    press(1'b1, 1'b1);
    cyc(1);
    n_run++; if (sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL both_run_state: got %0d want %0d", sif.state, ST_PAUSE); end
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL wrap_pause_tick: got %b want 1", sif.tick); end
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL both_run_clr: got %b want 0", sif.cnt_clr); end
    cyc(1);
    n_run++; if (sif.cnt_clr !== 1'b0 || sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL both_run_queued: got clr=%b st=%0d want clr=0 st=%0d", sif.cnt_clr, sif.state, ST_PAUSE); end
    cyc(2);
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL wrap_resume_state: got %0d want %0d", sif.state, ST_RUN); end
    cyc(9);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL wrap_hold_early: got %b want 0", sif.tick); end
    cyc(1);
    n_run++; if (sif.tick !== 1'b1) begin n_fail++; $display("FAIL wrap_hold_tick: got %b want 1", sif.tick); end
    cyc(2);
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_PAUSE) begin n_fail++; $display("FAIL both_pause_setup: got %0d want %0d", sif.state, ST_PAUSE); end
    cyc(2);
    press(1'b1, 1'b1);
    cyc(1);
    n_run++; if (sif.state !== ST_IDLE) begin n_fail++; $display("FAIL both_pause_state: got %0d want %0d", sif.state, ST_IDLE); end
    n_run++; if (sif.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL both_pause_clr: got %b want 1", sif.cnt_clr); end
    cyc(1);
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL both_pause_clr_width: got %b want 0", sif.cnt_clr); end
  endtask

  // Reset asserted on the edge where a tick would otherwise fire.
  task automatic test_reset_mid_run;
    int bad;
    cyc(2);
    press(1'b1, 1'b0);
    cyc(1);
    n_run++; if (sif.state !== ST_RUN) begin n_fail++; $display("FAIL mid_setup: got %0d want %0d", sif.state, ST_RUN); end
    cyc(9);
    rst = 1'b0;
    cyc(1);
    n_run++; if (sif.tick !== 1'b0) begin n_fail++; $display("FAIL mid_tick: got %b want 0", sif.tick); end
    n_run++; if (sif.state !== ST_IDLE) begin n_fail++; $display("FAIL mid_state: got %0d want %0d", sif.state, ST_IDLE); end
    n_run++; if (sif.cnt_clr !== 1'b1) begin n_fail++; $display("FAIL mid_clr: got %b want 1", sif.cnt_clr); end
    n_run++; if (sif.running !== 1'b0) begin n_fail++; $display("FAIL mid_running: got %b want 0", sif.running); end
    rst = 1'b1;
    cyc(1);
    n_run++; if (sif.cnt_clr !== 1'b0) begin n_fail++; $display("FAIL mid_clr_release: got %b want 0", sif.cnt_clr); end
    bad = 0;
    repeat (20) begin
      cyc(1);
      if (sif.tick !== 1'b0 || sif.state !== ST_IDLE) bad++;
    end
    n_run++; if (bad != 0) begin n_fail++; $display("FAIL mid_after: got %0d bad cycles want 0", bad); end
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b0;
    sif.btn_start = 1'b0;
    sif.btn_clear = 1'b0;
    test_reset;
    test_glitch;
    test_start_run;
    test_pause_resume;
    test_clear;
    test_simultaneous;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
